// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S master bus sequencer.
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } i2s_state_e;

   localparam int unsigned DEFAULT_WORD_BITS = 32;
   localparam int unsigned BIT_IDX_W         = $clog2(DEFAULT_WORD_BITS);

endpackage

// File: rtl/i2s_edge_timer.sv
// Half-period counter that toggles sck every div aclk cycles and emits
// registered rise/fall strobes coincident with the sck edge they mark.
module i2s_edge_timer #(
   parameter int CLK_DIV_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 run,
   input  logic [CLK_DIV_W-1:0] div,
   output logic                 sck,
   output logic                 rise,
   output logic                 fall,
   output logic                 fall_next
);

   logic [CLK_DIV_W-1:0] cnt;
   logic                 at_wrap;

   assign at_wrap = (cnt == div - CLK_DIV_W'(1));
   // Lets the owner update bit/slot state on the same edge sck drops.
   assign fall_next = run & at_wrap & sck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         sck  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else if (clear) begin
         cnt  <= '0;
         sck  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else if (run) begin
         if (at_wrap) begin
            cnt  <= '0;
            sck  <= ~sck;
            rise <= ~sck;
            fall <= sck;
         end else begin
            cnt  <= cnt + CLK_DIV_W'(1);
            rise <= 1'b0;
            fall <= 1'b0;
         end
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
      end
   end

endmodule

// File: rtl/i2s_bus_controller.sv
// I2S master bus sequencer: sck/ws generation with frame-aligned start/stop.
// Optional frame counter enabled by defining I2S_BUS_CTRL_FRAME_CNT_EN.
module i2s_bus_controller
   import i2s_pkg::*;
#(
   parameter int CLK_DIV_W   = 8,
   parameter int WORD_BITS   = DEFAULT_WORD_BITS,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         enable_in,
   input  logic [CLK_DIV_W-1:0]         div_in,
   output logic                         sck,
   output logic                         ws,
   output logic                         running_out,
   output logic                         sck_rise_out,
   output logic                         sck_fall_out,
   output logic [$clog2(WORD_BITS)-1:0] bit_idx_out,
   output logic                         frame_start_out,
   output logic [FRAME_CNT_W-1:0]       frame_cnt_out
);

   localparam int IDX_W = $clog2(WORD_BITS);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WORD_BITS - 1);

   function automatic logic [CLK_DIV_W-1:0] eff_div(input logic [CLK_DIV_W-1:0] d);
      return (d == '0) ? CLK_DIV_W'(1) : d;
   endfunction

   i2s_state_e           state, state_next;
   logic [CLK_DIV_W-1:0] div_q;
   logic                 start, stop;
   logic                 timer_run, fall_next;
   logic                 slot_wrap, frame_wrap;
   logic [IDX_W-1:0]     bit_idx;
   logic                 ws_q, frame_start_q, running_q;

   assign timer_run  = (state != ST_IDLE);
   assign slot_wrap  = fall_next && (bit_idx == LAST_BIT);
   assign frame_wrap = slot_wrap && ws_q;

   i2s_edge_timer #(
      .CLK_DIV_W (CLK_DIV_W)
   ) u_edge_timer (
      .clk       (aclk),
      .rst_n     (aresetn),
      .clear     (start),
      .run       (timer_run),
      .div       (div_q),
      .sck       (sck),
      .rise      (sck_rise_out),
      .fall      (sck_fall_out),
      .fall_next (fall_next)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      stop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable_in) begin
               state_next = ST_RUN;
               start      = 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable_in) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Only a frame boundary may end the bus; re-enable resumes mid-frame.
            if (frame_wrap && !enable_in) begin
               state_next = ST_IDLE;
               stop       = 1'b1;
            end else if (enable_in) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         div_q <= CLK_DIV_W'(1);
      end else if (start) begin
         div_q <= eff_div(div_in);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bit_idx       <= '0;
         ws_q          <= 1'b0;
         frame_start_q <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         running_q <= (state_next != ST_IDLE);
         if (start) begin
            bit_idx       <= '0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b1;
         end else if (stop) begin
            bit_idx       <= '0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
         end else if (fall_next) begin
            bit_idx       <= slot_wrap ? '0 : bit_idx + IDX_W'(1);
            ws_q          <= slot_wrap ? ~ws_q : ws_q;
            frame_start_q <= frame_wrap;
         end else begin
            frame_start_q <= 1'b0;
         end
      end
   end

`ifdef I2S_BUS_CTRL_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_cnt_q;

   // Held through IDLE so the last run's count stays visible until restart.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         frame_cnt_q <= '0;
      end else if (start) begin
         frame_cnt_q <= FRAME_CNT_W'(1);
      end else if (frame_wrap && !stop) begin
         frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
   end

   assign frame_cnt_out = frame_cnt_q;
`else
   assign frame_cnt_out = '0;
`endif

   assign ws              = ws_q;
   assign bit_idx_out     = bit_idx;
   assign frame_start_out = frame_start_q;
   assign running_out     = running_q;

endmodule

// File: tb/tb_i2s_bus_controller.sv
// Self-checking bench for i2s_bus_controller: timing-arithmetic reference model
// compared every cycle, plus directed literal checks and randomized enable/div/reset.
module tb_i2s_bus_controller;

   localparam int WB    = 32;
   localparam int IDX_W = 5;
   localparam int DW    = 8;
   localparam int FCW   = 16;

   logic           aclk = 1'b0;
   logic           aresetn = 1'b0;
   logic           enable_in = 1'b0;
   logic [DW-1:0]  div_in = 8'd2;
   logic           sck, ws, running_out, sck_rise_out, sck_fall_out, frame_start_out;
   logic [IDX_W-1:0] bit_idx_out;
   logic [FCW-1:0] frame_cnt_out;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   i2s_bus_controller #(
      .CLK_DIV_W   (DW),
      .WORD_BITS   (WB),
      .FRAME_CNT_W (FCW)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .enable_in       (enable_in),
      .div_in          (div_in),
      .sck             (sck),
      .ws              (ws),
      .running_out     (running_out),
      .sck_rise_out    (sck_rise_out),
      .sck_fall_out    (sck_fall_out),
      .bit_idx_out     (bit_idx_out),
      .frame_start_out (frame_start_out),
      .frame_cnt_out   (frame_cnt_out)
   );

   always #5 aclk = ~aclk;

   // Reference model: mode 0 idle, 1 run, 2 drain; outputs derive from phase arithmetic.
   int m_mode = 0;
   int m_phase = 0;
   int m_div = 1;
   int m_fc = 0;
   bit m_stopfall = 1'b0;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_mode = 0; m_phase = 0; m_div = 1; m_fc = 0; m_stopfall = 1'b0;
      end else begin
         int np, frame_len;
         bit bnd;
         m_stopfall = 1'b0;
         if (m_mode == 0) begin
            if (enable_in) begin
               m_mode = 1; m_phase = 0; m_fc = 1;
               m_div = (div_in == 0) ? 1 : int'(div_in);
            end
         end else begin
            frame_len = 4 * m_div * WB;
            np = m_phase + 1;
            bnd = (np % frame_len) == 0;
            if (m_mode == 2 && !enable_in && bnd) begin
               m_mode = 0; m_phase = 0; m_stopfall = 1'b1;
            end else begin
               m_phase = np;
               if (bnd) m_fc = (m_fc + 1) % 65536;
               m_mode = enable_in ? 1 : 2;
            end
         end
      end
   end

   always @(posedge aclk) cyc++;

   always @(negedge aclk) begin
      if (chk_en) begin
         logic [26:0] e, a;
         int per, fc_e;
`ifdef I2S_BUS_CTRL_FRAME_CNT_EN
         fc_e = m_fc;
`else
         fc_e = 0;
`endif
         per = 2 * m_div;
         if (!aresetn) begin
            e = '0;
         end else if (m_mode == 0) begin
            e = {1'b0, 1'b0, 1'b0, 1'b0, m_stopfall, 1'b0, 5'd0, 16'(fc_e)};
         end else begin
            e = {1'b1,
                 1'((m_phase / m_div) % 2),
                 1'((m_phase / (per * WB)) % 2),
                 1'(m_phase % per == m_div),
                 1'(m_phase > 0 && m_phase % per == 0),
                 1'(m_phase % (per * 2 * WB) == 0),
                 5'((m_phase / per) % WB),
                 16'(fc_e)};
         end
         a = {running_out, sck, ws, sck_rise_out, sck_fall_out, frame_start_out,
              bit_idx_out, frame_cnt_out};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL model_cycle %0d: got run/sck/ws/rise/fall/fs/bit/fc=%b expected %b",
                     cyc, a, e);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #2;
   endtask

   task automatic wait_rise(output int c);
      c = -1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge aclk);
         if (sck_rise_out) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) check("wait_rise_timeout", 1, 0);
   endtask

   task automatic rise_period(output int p);
      int c0, c1;
      wait_rise(c0);
      wait_rise(c1);
      p = c1 - c0;
   endtask

   task automatic stop_bus();
      bit seen;
      seen = 1'b0;
      step();
      enable_in = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge aclk);
         if (!running_out) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("stop_timeout", 1, 0);
      step();
   endtask

   task automatic wait_running();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (running_out) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("start_timeout", 1, 0);
   endtask

   int exp_fc1;
   initial begin
      int c0, ws0, ws1, span, p, rises, gaps;
      bit seen;
`ifdef I2S_BUS_CTRL_FRAME_CNT_EN
      exp_fc1 = 1;
`else
      exp_fc1 = 0;
`endif
      repeat (3) @(posedge aclk);
      chk_en = 1'b1;
      #2 aresetn = 1'b1;
      @(negedge aclk);
      check("reset_running", int'(running_out), 0);
      check("reset_sck_ws", int'({sck, ws}), 0);

      // Start with div 2: first frame layout and periods.
      step();
      div_in = 8'd2;
      enable_in = 1'b1;
      @(negedge aclk);
      check("idle_before_sample", int'(running_out), 0);
      @(negedge aclk);
      check("run_entry_running", int'(running_out), 1);
      check("run_entry_frame_start", int'(frame_start_out), 1);
      check("run_entry_frame_cnt", int'(frame_cnt_out), exp_fc1);
      c0 = cyc; ws0 = 0; ws1 = 0; span = -1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge aclk);
         if (sck_rise_out) begin
            if (ws) ws1++; else ws0++;
         end
         if (frame_start_out) begin
            span = cyc - c0;
            break;
         end
      end
      check("frame_interval", span, 256);
      check("left_rises", ws0, 32);
      check("right_rises", ws1, 32);
      rise_period(p);
      check("period_div2", p, 4);

      // Drop enable just after the bit-10 rise of a right slot.
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge aclk);
         if (sck_rise_out && ws && bit_idx_out == 5'd10) begin
            seen = 1'b1;
            break;
         end
      end
      check("found_right_bit10", int'(seen), 1);
      step();
      enable_in = 1'b0;
      rises = 0; seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge aclk);
         if (!running_out) begin
            seen = 1'b1;
            break;
         end
         if (sck_rise_out) rises++;
      end
      check("drain_stopped", int'(seen), 1);
      check("drain_rises", rises, 21);
      check("drain_idle_sck_ws", int'({sck, ws}), 0);
      repeat (5) step();

      // div 0 acts as div 1.
      div_in = 8'd0;
      enable_in = 1'b1;
      wait_running();
      rise_period(p);
      check("period_div0", p, 2);
      stop_bus();

      // div change mid-run takes effect only after restart.
      div_in = 8'd2;
      enable_in = 1'b1;
      wait_running();
      repeat (7) step();
      div_in = 8'd5;
      rise_period(p);
      check("period_div_held", p, 4);
      stop_bus();
      enable_in = 1'b1;
      wait_running();
      rise_period(p);
      check("period_div5", p, 10);

      // Drop and reassert inside DRAIN: bus must keep running.
      step();
      enable_in = 1'b0;
      repeat (60) step();
      enable_in = 1'b1;
      gaps = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge aclk);
         if (!running_out) gaps++;
      end
      check("drain_reassert_gaps", gaps, 0);

      // Asynchronous reset mid-frame while sck is high.
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge aclk);
         if (sck && bit_idx_out > 5'd3) begin
            seen = 1'b1;
            break;
         end
      end
      check("found_sck_high", int'(seen), 1);
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      #1;
      check("async_reset_outputs",
            int'({running_out, sck, ws, sck_rise_out, sck_fall_out, frame_start_out,
                  bit_idx_out, frame_cnt_out}), 0);
      enable_in = 1'b1;
      div_in = 8'd3;
      step();
      aresetn = 1'b1;
      wait_running();
      check("restart_frame_cnt", int'(frame_cnt_out), exp_fc1);
      check("restart_frame_start", int'(frame_start_out), 1);

      // Randomized enable/div/reset traffic, checked by the model every cycle.
      for (int k = 0; k < 40; k++) begin
         int r;
         r = int'($urandom_range(0, 11));
         step();
         if (r == 0) begin
            aresetn = 1'b0;
            repeat (int'($urandom_range(1, 3))) step();
            aresetn = 1'b1;
         end else begin
            enable_in = (r > 4);
            div_in = DW'($urandom_range(0, 3));
            repeat (int'($urandom_range(1, 400))) step();
         end
      end
      stop_bus();
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/i2s_bus_controller.md
# i2s_bus_controller

Master-side I2S bus sequencer: generates `sck` and `ws` from the system clock, plus aligned bit/edge strobes that let one or more `i2s_receiver` instances sample `sd` without re-detecting edges. Starts and stops only on frame boundaries, so downstream receivers never see a truncated word. Sits between the system clock domain and the microphone pins, replacing the free-running clock generator in the audio capture path.

## Interface
Parameters:
- `CLK_DIV_W`, 8: width of the runtime divider input.
- `WORD_BITS`, 32: sck cycles per channel slot; frame = 2*WORD_BITS sck cycles.
- `FRAME_CNT_W`, 16: width of the frame counter.

Ports:
- `aclk` in 1: system clock (100 MHz nominal).
- `aresetn` in 1: reset; one clock; asynchronous, active-low.
- `enable_in` in 1: level request to run the bus.
- `div_in` in CLK_DIV_W: aclk cycles per sck half-period; 0 treated as 1.
- `sck` out 1: I2S serial clock.
- `ws` out 1: word select; 0 = left slot, 1 = right slot.
- `running_out` out 1: high while the bus is clocking (RUN or DRAIN).
- `sck_rise_out` out 1: one-cycle strobe in the cycle `sck` becomes 1.
- `sck_fall_out` out 1: one-cycle strobe in the cycle `sck` becomes 0.
- `bit_idx_out` out $clog2(WORD_BITS): sck index within current slot.
- `frame_start_out` out 1: one-cycle strobe at start of each left slot.
- `frame_cnt_out` out FRAME_CNT_W: frames started since leaving IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `sck`=0, `ws`=0, counters 0. `enable_in`=1 -> RUN next cycle; `div_in` latched on this transition only (changes mid-run ignored until next IDLE->RUN).
- RUN entry cycle: `frame_start_out`=1, `frame_cnt_out` becomes 1, `bit_idx_out`=0, `ws`=0.
- Half-period counter counts 0..div-1; at div-1 it wraps and `sck` toggles.
- On each sck falling transition: `bit_idx_out` increments; at WORD_BITS-1 -> 0 wrap `ws` toggles in the same cycle. When `ws` goes 1->0, `frame_start_out` pulses and `frame_cnt_out` increments (wraps at 2^FRAME_CNT_W silently).
- RUN with `enable_in`=0 -> DRAIN. DRAIN keeps clocking; at the falling edge that would begin a new frame (ws 1->0) -> IDLE instead: `sck`,`ws` stay 0, no `frame_start_out`, `running_out` drops that cycle.
- DRAIN with `enable_in`=1 -> RUN, no glitch, frame continues.
- `aresetn` low at any time: all outputs 0 immediately, state IDLE; a partial frame is abandoned.

## Timing
- Reset values: all outputs 0.
- IDLE->RUN: `running_out` rises 1 cycle after `enable_in` sampled high; first `sck` rise div cycles after RUN entry.
- sck period = 2*div aclk cycles, 50% duty; frame = 2*WORD_BITS*2*div aclk cycles.
- Strobes are registered and coincident with the output edge they mark; `sd` should be sampled by receivers on `sck_rise_out`.
- Stop latency: at most one full frame plus one cycle after `enable_in` falls.

## Configuration
- `I2S_BUS_CTRL_FRAME_CNT_EN`: defined -> frame counter implemented as above. Undefined -> counter logic omitted, `frame_cnt_out` tied to 0; all other behaviour identical.

## Structure
- Shared package `i2s_pkg`: state enum (IDLE/RUN/DRAIN), default WORD_BITS, bit-index width localparam.
- One sub-module `i2s_edge_timer`: half-period counter plus sck toggle and rise/fall strobes, with a load/clear input; the FSM, bit/ws/frame logic stay in the top.

## Test plan
- Reset then `enable_in`=1, `div_in`=2 -> `sck` period 4 aclk, 32 rises with `ws`=0, then 32 with `ws`=1; `frame_start_out` every 256 aclk.
- `div_in`=0 -> behaves as div 1: `sck` period 2 aclk.
- Drop `enable_in` mid right slot (bit 10) -> bus completes 21 more sck cycles, then `sck`=`ws`=0, `running_out`=0, `frame_cnt_out` holds.
- Drop then reassert `enable_in` within DRAIN -> no gap in `sck`, `frame_cnt_out` keeps incrementing.
- Change `div_in` 2->5 mid-run -> period stays 4 until IDLE, then 10 after restart.
- Assert `aresetn`=0 mid-frame -> all outputs 0 same cycle; release with `enable_in`=1 -> clean restart, `frame_cnt_out`=1.
